// File: rtl/fast_bconv_ex_stream_pkg.sv
// fast_bconv_ex_stream_pkg: residue types, slot count (`N_SLOTS, default 8) and toy conversion bases/LUTs.
`ifndef N_SLOTS
`define N_SLOTS 8
`endif
package fast_bconv_ex_stream_pkg;
    localparam int RNS_PRIME_BITS = 5;
    localparam int N_SLOTS = `N_SLOTS;
    typedef logic [RNS_PRIME_BITS-1:0] rns_residue_t;
    typedef logic [2*RNS_PRIME_BITS+1:0] wide_rns_residue_t;
    typedef logic signed [RNS_PRIME_BITS:0] signed_rns_residue_t;
    typedef logic signed [2*RNS_PRIME_BITS+1:0] signed_wide_rns_residue_t;
    // B = {7, 11} (B = 77), Ba = 13, q = {17, 19}
    localparam int DEF_IN_BASIS [2] = '{7, 11};
    localparam int DEF_OUT_BASIS [2] = '{17, 19};
    localparam int DEF_BA_MODULUS = 13;
    // (B/b_i)^-1 mod b_i
    localparam int DEF_ZINV_LUT [2] = '{2, 8};
    // (B/b_i) mod q_j and (B/b_i) mod Ba
    localparam int DEF_Y_TO_OUT [2][2] = '{'{11, 11}, '{7, 7}};
    localparam int DEF_Y_TO_BA [2] = '{11, 7};
    // B^-1 mod Ba and B mod q_j
    localparam int DEF_BINV_MOD_BA = 12;
    localparam int DEF_SIGNED_B_MOD_OUT [2] = '{9, 1};
    function automatic rns_residue_t mulmod(rns_residue_t a, int b, int m);
        wide_rns_residue_t p;
        p = wide_rns_residue_t'(a) * wide_rns_residue_t'(b);
        return rns_residue_t'(p % wide_rns_residue_t'(m));
    endfunction
endpackage

// File: rtl/fast_bconv_ex_stream_if.sv
// fast_bconv_ex_stream_if: input and output beat streams of the base converter.
interface fast_bconv_ex_stream_if
    import fast_bconv_ex_stream_pkg::*;
#(
    parameter int LANES = 4,
    parameter int IN_BASIS_LEN = 2,
    parameter int OUT_BASIS_LEN = 2
) ();
    logic in_valid;
    logic in_ready;
    rns_residue_t [LANES-1:0][IN_BASIS_LEN:0] in_data;
    logic out_valid;
    logic out_ready;
    logic out_last;
    rns_residue_t [LANES-1:0][OUT_BASIS_LEN-1:0] out_data;
    modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_last);
    modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/fast_bconv_ex_stream_modred.sv
// rns_modred_signed: reduces a signed value to its non-negative residue in [0, MOD).
module rns_modred_signed
    import fast_bconv_ex_stream_pkg::*;
#(
    parameter int MOD = 13,
    parameter int IN_W = RNS_PRIME_BITS + 1
) (
    input  logic signed [IN_W-1:0] i_val,
    output rns_residue_t           o_res
);
    localparam logic signed [IN_W-1:0] L_MOD = IN_W'(MOD);
    logic signed [IN_W-1:0] w_rem;
    assign w_rem = i_val % L_MOD;
    assign o_res = rns_residue_t'(w_rem[IN_W-1] ? w_rem + L_MOD : w_rem);
endmodule

// File: rtl/fast_bconv_ex_stream.sv
// fast_bconv_ex_stream: 4-stage exact RNS base conversion B -> OUT_BASIS using a redundant Ba residue.
// Build option FBCONVEX_GAMMA_CENTER_EN centres gamma so signed inputs |x| < B/2 convert exactly.
module fast_bconv_ex_stream
    import fast_bconv_ex_stream_pkg::*;
#(
    parameter int IN_BASIS_LEN = 2,
    parameter int OUT_BASIS_LEN = 2,
    parameter int LANES = 4,
    parameter int IN_BASIS [IN_BASIS_LEN] = DEF_IN_BASIS,
    parameter int OUT_BASIS [OUT_BASIS_LEN] = DEF_OUT_BASIS,
    parameter int BA_MODULUS = DEF_BA_MODULUS,
    parameter int ZINV_LUT [IN_BASIS_LEN] = DEF_ZINV_LUT,
    parameter int Y_TO_OUT [IN_BASIS_LEN][OUT_BASIS_LEN] = DEF_Y_TO_OUT,
    parameter int Y_TO_BA [IN_BASIS_LEN] = DEF_Y_TO_BA,
    parameter int BINV_MOD_BA = DEF_BINV_MOD_BA,
    parameter int SIGNED_B_MOD_OUT [OUT_BASIS_LEN] = DEF_SIGNED_B_MOD_OUT
) (
    input logic clk,
    input logic reset,
    fast_bconv_ex_stream_if.slave bus
);
    localparam int NBEATS = N_SLOTS / LANES;
    localparam int CW = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    if ((N_SLOTS % LANES) != 0 || IN_BASIS_LEN < 1) begin : g_bad_cfg
        $fatal(1, "fast_bconv_ex_stream: N_SLOTS must be a multiple of LANES and IN_BASIS_LEN >= 1");
    end

    logic [3:0] r_v;
    logic [CW-1:0] r_cnt;
    logic w_stall;
    logic w_out_hs;
    rns_residue_t [LANES-1:0][IN_BASIS_LEN-1:0] w_y;
    rns_residue_t [LANES-1:0][IN_BASIS_LEN-1:0] r_s1_y;
    rns_residue_t [LANES-1:0] r_s1_xba;
    rns_residue_t [LANES-1:0] r_s2_xba;
    rns_residue_t [LANES-1:0] r_s2_cba;
    rns_residue_t [LANES-1:0] w_d;
    rns_residue_t [LANES-1:0] w_gu;
    wide_rns_residue_t [LANES-1:0] w_acc_ba;
    wide_rns_residue_t [LANES-1:0][OUT_BASIS_LEN-1:0] w_acc_out;
    rns_residue_t [LANES-1:0][OUT_BASIS_LEN-1:0] r_s2_cout;
    rns_residue_t [LANES-1:0][OUT_BASIS_LEN-1:0] r_s3_cout;
    rns_residue_t [LANES-1:0][OUT_BASIS_LEN-1:0] w_o;
    rns_residue_t [LANES-1:0][OUT_BASIS_LEN-1:0] r_s4_out;
    signed_rns_residue_t w_diff [LANES];
    signed_rns_residue_t w_g [LANES];
    signed_rns_residue_t r_s3_g [LANES];
    signed_wide_rns_residue_t w_v [LANES][OUT_BASIS_LEN];

    // The whole pipeline freezes only when the output beat is refused.
    assign w_stall = r_v[3] && !bus.out_ready;
    assign w_out_hs = r_v[3] && bus.out_ready;
    assign bus.in_ready = !w_stall;
    assign bus.out_valid = r_v[3];
    assign bus.out_last = r_v[3] && (r_cnt == CW'(NBEATS - 1));
    assign bus.out_data = r_s4_out;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        for (genvar i = 0; i < IN_BASIS_LEN; i++) begin : g_in
            assign w_y[l][i] = mulmod(bus.in_data[l][i], ZINV_LUT[i], IN_BASIS[i]);
        end
        assign w_diff[l] = signed_rns_residue_t'({1'b0, r_s2_cba[l]}) - signed_rns_residue_t'({1'b0, r_s2_xba[l]});
        rns_modred_signed #(.MOD(BA_MODULUS), .IN_W(RNS_PRIME_BITS + 1)) u_gamma_mod (
            .i_val(w_diff[l]),
            .o_res(w_d[l])
        );
        assign w_gu[l] = mulmod(w_d[l], BINV_MOD_BA, BA_MODULUS);
`ifdef FBCONVEX_GAMMA_CENTER_EN
        assign w_g[l] = (int'(w_gu[l]) > BA_MODULUS / 2)
                      ? signed_rns_residue_t'({1'b0, w_gu[l]}) - signed_rns_residue_t'(BA_MODULUS)
                      : signed_rns_residue_t'({1'b0, w_gu[l]});
`else
        assign w_g[l] = signed_rns_residue_t'({1'b0, w_gu[l]});
`endif
        for (genvar j = 0; j < OUT_BASIS_LEN; j++) begin : g_out
            assign w_v[l][j] = signed_wide_rns_residue_t'(r_s3_cout[l][j])
                             - signed_wide_rns_residue_t'(r_s3_g[l]) * signed_wide_rns_residue_t'(SIGNED_B_MOD_OUT[j]);
            rns_modred_signed #(.MOD(OUT_BASIS[j]), .IN_W(2 * RNS_PRIME_BITS + 2)) u_out_mod (
                .i_val(w_v[l][j]),
                .o_res(w_o[l][j])
            );
        end
    end

    // Fast base conversion sums: each term is pre-reduced so the wide accumulator cannot overflow.
    always_comb begin
        w_acc_ba = '0;
        w_acc_out = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int i = 0; i < IN_BASIS_LEN; i++) begin
                w_acc_ba[l] = w_acc_ba[l] + wide_rns_residue_t'(mulmod(r_s1_y[l][i], Y_TO_BA[i], BA_MODULUS));
                for (int j = 0; j < OUT_BASIS_LEN; j++) begin
                    w_acc_out[l][j] = w_acc_out[l][j] + wide_rns_residue_t'(mulmod(r_s1_y[l][i], Y_TO_OUT[i][j], OUT_BASIS[j]));
                end
            end
        end
    end

    // Stage valid bits and the per-polynomial beat counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_v <= '0;
            r_cnt <= '0;
        end else begin
            if (!w_stall) r_v <= {r_v[2:0], bus.in_valid};
            if (w_out_hs) r_cnt <= (r_cnt == CW'(NBEATS - 1)) ? '0 : r_cnt + CW'(1);
        end
    end

    // Stage data registers; unreset since valid bits qualify them.
    always_ff @(posedge clk) begin
        if (!w_stall) begin
            r_s1_y <= w_y;
            r_s2_xba <= r_s1_xba;
            r_s3_cout <= r_s2_cout;
            r_s4_out <= w_o;
            for (int l = 0; l < LANES; l++) begin
                r_s1_xba[l] <= bus.in_data[l][IN_BASIS_LEN];
                r_s2_cba[l] <= rns_residue_t'(w_acc_ba[l] % wide_rns_residue_t'(BA_MODULUS));
                r_s3_g[l] <= w_g[l];
                for (int j = 0; j < OUT_BASIS_LEN; j++) begin
                    r_s2_cout[l][j] <= rns_residue_t'(w_acc_out[l][j] % wide_rns_residue_t'(OUT_BASIS[j]));
                end
            end
        end
    end
endmodule

// File: tb/tb_fast_bconv_ex_stream.sv
// tb_fast_bconv_ex_stream: directed and random beats checked against exact x mod q arithmetic.
module tb_fast_bconv_ex_stream;
    import fast_bconv_ex_stream_pkg::*;
    localparam int NL = 4;
    localparam int NB = 2;
    typedef rns_residue_t [NL-1:0][1:0] out_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_hs = 1'b0;
    logic rnd_rdy = 1'b0;
    int checks = 0;
    int errors = 0;
    int beat_idx = 0;
    out_t exp_q [$];
    out_t cur_exp;
    out_t snap;

    fast_bconv_ex_stream_if #(.LANES(NL), .IN_BASIS_LEN(2), .OUT_BASIS_LEN(2)) bus ();

    fast_bconv_ex_stream dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic int pmod(int a, int m);
        return ((a % m) + m) % m;
    endfunction

    function automatic int rand_x();
`ifdef FBCONVEX_GAMMA_CENTER_EN
        return int'($urandom_range(76)) - 38;
`else
        return int'($urandom_range(76));
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_lane(input int l, input int x);
        bus.in_data[l][0] = rns_residue_t'(pmod(x, 7));
        bus.in_data[l][1] = rns_residue_t'(pmod(x, 11));
        bus.in_data[l][2] = rns_residue_t'(pmod(x, 13));
        cur_exp[l][0] = rns_residue_t'(pmod(x, 17));
        cur_exp[l][1] = rns_residue_t'(pmod(x, 19));
    endtask

    task automatic tick();
        out_t e;
        @(negedge clk);
        in_hs = 1'b0;
        if (!reset) begin
            if (bus.out_valid && bus.out_ready) begin
                check("beat_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("beat_data", bus.out_data, e);
                    check("beat_last", bus.out_last, beat_idx == NB - 1);
                    beat_idx = (beat_idx + 1) % NB;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(cur_exp);
                in_hs = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (rnd_rdy) bus.out_ready = ($urandom_range(3) != 0);
    endtask

    task automatic send_beat();
        bus.in_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (in_hs) break;
        end
        check("send_accepted", in_hs, 1'b1);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_x(input int x);
        for (int l = 0; l < NL; l++) load_lane(l, x);
        send_beat();
    endtask

    task automatic send_rand();
        for (int l = 0; l < NL; l++) load_lane(l, rand_x());
        send_beat();
    endtask

    task automatic wait_out();
        for (int k = 0; k < 20; k++) begin
            if (bus.out_valid) break;
            tick();
        end
        check("out_valid_wait", bus.out_valid, 1'b1);
    endtask

    task automatic drain();
        for (int k = 0; k < 40; k++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b1;
        cur_exp = '0;
        reset = 1'b1;
        tick();
        tick();
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_last", bus.out_last, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        reset = 1'b0;
        tick();

        for (int l = 0; l < NL; l++) load_lane(l, 5);
        bus.in_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            bus.in_valid = 1'b0;
            check("latency_valid", bus.out_valid, k == 4);
        end
        check("x5_q0", bus.out_data[0][0], 5);
        check("x5_q1", bus.out_data[0][1], 5);
        check("x5_last", bus.out_last, 1'b0);

`ifdef FBCONVEX_GAMMA_CENTER_EN
        send_x(-3);
        wait_out();
        check("xm3_q0", bus.out_data[0][0], 14);
        check("xm3_q1", bus.out_data[0][1], 16);
`else
        send_x(76);
        wait_out();
        check("x76_q0", bus.out_data[0][0], 8);
        check("x76_q1", bus.out_data[0][1], 0);
`endif
        check("second_last", bus.out_last, 1'b1);
        drain();

        send_rand();
        send_rand();
        send_rand();
        send_rand();
        drain();

        rnd_rdy = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(2) != 0) send_rand();
            else tick();
        end
        rnd_rdy = 1'b0;
        bus.out_ready = 1'b1;
        drain();

        bus.out_ready = 1'b0;
        send_rand();
        wait_out();
        snap = bus.out_data;
        for (int l = 0; l < NL; l++) load_lane(l, rand_x());
        bus.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_data", bus.out_data, snap);
            check("stall_in_ready", bus.in_ready, 1'b0);
            check("stall_out_valid", bus.out_valid, 1'b1);
        end
        bus.out_ready = 1'b1;
        send_beat();
        drain();

        send_rand();
        send_rand();
        send_rand();
        reset = 1'b1;
        exp_q.delete();
        beat_idx = 0;
        tick();
        check("midrst_out_valid", bus.out_valid, 1'b0);
        check("midrst_out_last", bus.out_last, 1'b0);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("no_stale_beat", bus.out_valid, 1'b0);
        end
        send_rand();
        send_rand();
        drain();
        tick();
        check("end_idle", bus.out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
